unified_mem_arbiter: RTL and testbench

- Sequences one shared single-port memory between the pipeline's instruction-fetch (IF) and data-access (MEM) stages.
- Data requests take priority. Requests are latched, memory wait-states are absorbed, and per-stage stall signals go to the pipeline control logic.
- A watchdog aborts any access the memory never acknowledges.
- Sits between the 5-stage core and the unified memory model.

---
 rtl/unified_mem_arbiter_pkg.sv | 14 +
 rtl/unified_mem_arbiter_if.sv | 43 ++++
 rtl/unified_mem_arbiter_mem_watchdog.sv | 31 +++
 rtl/unified_mem_arbiter.sv | 146 ++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/unified_mem_arbiter_pkg.sv
// Shared definitions for the unified IF/MEM memory arbiter: default bus widths
// and the arbiter FSM state encoding.
package unified_mem_arbiter_pkg;

    localparam int unsigned DEF_AW = 32;
    localparam int unsigned DEF_DW = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_IBUSY = 2'd1,
        ST_DBUSY = 2'd2
    } state_e;

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Request/response bundle between the core's IF/MEM stages, the arbiter and the
// unified memory. The arbiter takes the slave side; the core/memory environment the master side.
interface unified_mem_arbiter_if
    import unified_mem_arbiter_pkg::*;
#(
    parameter int unsigned AW = DEF_AW,
    parameter int unsigned DW = DEF_DW
);
    logic              i_req;
    logic [AW-1:0]     i_addr;
    logic [DW-1:0]     i_rdata;
    logic              i_valid;
    logic              d_req;
    logic              d_we;
    logic [AW-1:0]     d_addr;
    logic [DW-1:0]     d_wdata;
    logic [DW/8-1:0]   d_be;
    logic [DW-1:0]     d_rdata;
    logic              d_valid;
    logic              stall_f;
    logic              stall_m;
    logic              bus_err;
    logic              mem_req;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [DW/8-1:0]   mem_be;
    logic              mem_ready;
    logic [DW-1:0]     mem_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_ready, mem_rdata,
        output i_rdata, i_valid, d_rdata, d_valid, stall_f, stall_m, bus_err,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_ready, mem_rdata,
        input  i_rdata, i_valid, d_rdata, d_valid, stall_f, stall_m, bus_err,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

endinterface

// File: rtl/unified_mem_arbiter_mem_watchdog.sv
// Saturating busy-cycle counter; flags an access that has waited TIMEOUT_CYC
// cycles without a memory acknowledge.
module mem_watchdog #(
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic timeout
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] MAX   = '1;

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && (cnt_q != MAX)) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign timeout = en && (cnt_q == LIMIT);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port memory between instruction fetch and data access,
// data first, with latched requests, wait-state absorption and a timeout abort.
module unified_mem_arbiter
    import unified_mem_arbiter_pkg::*;
#(
    parameter int unsigned AW          = DEF_AW,
    parameter int unsigned DW          = DEF_DW,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input logic                  clk,
    input logic                  rst_n,
    unified_mem_arbiter_if.slave bus
);

    localparam int unsigned BW = DW / 8;

    state_e          state_q, state_d;
    logic            mem_req_q, mem_req_d;
    logic            mem_we_q, mem_we_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
    logic [BW-1:0]   mem_be_q, mem_be_d;
    logic            i_valid_q, i_valid_d;
    logic            d_valid_q, d_valid_d;
    logic [DW-1:0]   i_rdata_q, i_rdata_d;
    logic [DW-1:0]   d_rdata_q, d_rdata_d;
    logic            bus_err_q, bus_err_d;
    logic            busy, mem_done, d_pend, i_pend;
    logic            wd_clr, wd_en, timeout;
    logic [DW-1:0]   rsp;

    assign busy  = (state_q != ST_IDLE);
    assign wd_en = busy && !bus.mem_ready;

    mem_watchdog #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (wd_clr),
        .en     (wd_en),
        .timeout(timeout)
    );

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        i_valid_d   = 1'b0;
        d_valid_d   = 1'b0;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        bus_err_d   = 1'b0;
        wd_clr      = 1'b0;
        rsp         = '0;

        mem_done = busy && (bus.mem_ready || timeout);
        // A requester whose valid is out now, or who owns the finishing access, is not pending.
        d_pend = bus.d_req && !d_valid_q && (state_q != ST_DBUSY);
        i_pend = bus.i_req && !i_valid_q && (state_q != ST_IBUSY);

        if (mem_done) begin
            // mem_ready beats a coincident timeout; stores and aborts return zero.
            if (bus.mem_ready && !mem_we_q) begin
                rsp = bus.mem_rdata;
            end
            bus_err_d = !bus.mem_ready;
            if (state_q == ST_DBUSY) begin
                d_valid_d = 1'b1;
                d_rdata_d = rsp;
            end else begin
                i_valid_d = 1'b1;
                i_rdata_d = rsp;
            end
        end

        if (!busy || mem_done) begin
            if (d_pend) begin
                state_d     = ST_DBUSY;
                mem_req_d   = 1'b1;
                mem_we_d    = bus.d_we;
                mem_addr_d  = bus.d_addr;
                mem_wdata_d = bus.d_wdata;
                mem_be_d    = bus.d_we ? bus.d_be : '1;
                wd_clr      = 1'b1;
            end else if (i_pend) begin
                state_d     = ST_IBUSY;
                mem_req_d   = 1'b1;
                mem_we_d    = 1'b0;
                mem_addr_d  = bus.i_addr;
                mem_wdata_d = '0;
                mem_be_d    = '1;
                wd_clr      = 1'b1;
            end else begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            i_valid_q   <= 1'b0;
            d_valid_q   <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            i_valid_q   <= i_valid_d;
            d_valid_q   <= d_valid_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.i_valid   = i_valid_q;
    assign bus.d_valid   = d_valid_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.bus_err   = bus_err_q;
    assign bus.stall_f   = bus.i_req && !i_valid_q;
    assign bus.stall_m   = bus.d_req && !d_valid_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter: cycle tables, directed corner
// sequences, then random traffic against a transaction-level memory model.
module tb_unified_mem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    unified_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    unified_mem_arbiter #(
        .AW         (AW),
        .DW         (DW),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // ins = {i_req, d_req, d_we, mem_ready}
    // ex  = {mem_req, mem_we, i_valid, d_valid, stall_f, stall_m, check_addr}
    typedef struct packed {
        logic [3:0]  ins;
        logic [6:0]  ex;
        logic [31:0] e_addr;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t tbl[11];

    logic [31:0] ref_mem[16];
    logic [31:0] phys_mem[16];
    logic        f_done, d_done;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b want %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Requests must stay up until their valid pulse.
    logic pi = 1'b0, pd = 1'b0;
    always @(posedge clk) begin
        if (rst_n && pi && !bus.i_req && !bus.i_valid) $error("protocol: i_req dropped early");
        if (rst_n && pd && !bus.d_req && !bus.d_valid) $error("protocol: d_req dropped early");
        pi <= rst_n && bus.i_req && !bus.i_valid;
        pd <= rst_n && bus.d_req && !bus.d_valid;
    end

    task automatic run_fetch(input int n);
        for (int t = 0; t < n; t++) begin
            int unsigned idx;
            int          cnt;
            logic        err;
            logic [31:0] exp;
            repeat ($urandom_range(2, 0)) step();
            idx = $urandom_range(9, 0);
            if (idx >= 8) idx = idx + 8;
            err = (idx >= 16);
            exp = err ? 32'h0 : ref_mem[idx];
            bus.i_addr = 32'(idx * 4);
            bus.i_req  = 1'b1;
            cnt = 0;
            do begin
                step();
                cnt++;
            end while (!bus.i_valid && cnt < 80);
            chk1("rnd fetch completes", bus.i_valid, 1'b1);
            if (bus.i_valid) begin
                chk32("rnd fetch rdata", bus.i_rdata, exp);
                chk1("rnd fetch bus_err", bus.bus_err, err);
            end
            bus.i_req = 1'b0;
        end
        f_done = 1'b1;
    endtask

    task automatic run_data(input int n);
        for (int t = 0; t < n; t++) begin
            int unsigned idx;
            int          cnt;
            logic        we, err;
            logic [31:0] wd, exp;
            logic [3:0]  be;
            repeat ($urandom_range(2, 0)) step();
            idx = $urandom_range(17, 0);
            we  = (idx >= 8) ? 1'($urandom_range(1, 0)) : 1'b0;
            wd  = $urandom;
            be  = 4'($urandom);
            err = (idx >= 16);
            exp = (err || we) ? 32'h0 : ref_mem[idx];
            bus.d_addr  = 32'(idx * 4);
            bus.d_we    = we;
            bus.d_wdata = wd;
            bus.d_be    = be;
            bus.d_req   = 1'b1;
            cnt = 0;
            do begin
                step();
                cnt++;
            end while (!bus.d_valid && cnt < 80);
            chk1("rnd data completes", bus.d_valid, 1'b1);
            if (bus.d_valid) begin
                chk32("rnd data rdata", bus.d_rdata, exp);
                chk1("rnd data bus_err", bus.bus_err, err);
            end
            if (!err && we) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
                end
            end
            bus.d_req = 1'b0;
        end
        d_done = 1'b1;
    endtask

    // Memory: 0..3 wait states on live words, silence on words 16 and up.
    task automatic run_mem();
        logic        serving = 1'b0;
        int          wait_left = 0;
        int          s_cyc = 0;
        logic [31:0] s_addr = '0, s_wdata = '0;
        logic [3:0]  s_be = '0;
        logic        s_we = 1'b0;
        int unsigned idx;
        while (!(f_done && d_done)) begin
            bus.mem_ready = 1'b0;
            bus.mem_rdata = $urandom;
            if (bus.mem_req) begin
                if (!serving) begin
                    serving   = 1'b1;
                    wait_left = $urandom_range(3, 0);
                    s_cyc     = 0;
                    s_addr    = bus.mem_addr;
                    s_wdata   = bus.mem_wdata;
                    s_be      = bus.mem_be;
                    s_we      = bus.mem_we;
                end else begin
                    chk32("busy mem_addr stable", bus.mem_addr, s_addr);
                    chk32("busy mem_ctl stable", {27'h0, bus.mem_we, bus.mem_be}, {27'h0, s_we, s_be});
                    chk32("busy mem_wdata stable", bus.mem_wdata, s_wdata);
                end
                s_cyc++;
                idx = 32'(s_addr[31:2]);
                if (idx < 16) begin
                    if (wait_left == 0) begin
                        bus.mem_ready = 1'b1;
                        serving = 1'b0;
                        if (s_we) begin
                            for (int b = 0; b < 4; b++) begin
                                if (s_be[b]) phys_mem[idx][8*b +: 8] = s_wdata[8*b +: 8];
                            end
                        end else begin
                            bus.mem_rdata = phys_mem[idx];
                        end
                    end else begin
                        wait_left--;
                    end
                end else if (s_cyc == int'(TO)) begin
                    serving = 1'b0;
                end
            end else begin
                serving = 1'b0;
            end
            step();
        end
        bus.mem_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global timeout: simulation did not finish");
        $fatal(1, "bench time limit reached");
    end

    initial begin
        bus.i_req = 1'b0; bus.i_addr = '0; bus.d_req = 1'b0; bus.d_we = 1'b0;
        bus.d_addr = '0; bus.d_wdata = '0; bus.d_be = '0;
        bus.mem_ready = 1'b0; bus.mem_rdata = '0;
        f_done = 1'b0; d_done = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk1("reset mem_req", bus.mem_req, 1'b0);
        chk1("reset mem_we", bus.mem_we, 1'b0);
        chk1("reset i_valid", bus.i_valid, 1'b0);
        chk1("reset d_valid", bus.d_valid, 1'b0);
        chk1("reset bus_err", bus.bus_err, 1'b0);
        chk32("reset mem_addr", bus.mem_addr, 32'h0);
        chk32("reset mem_wdata", bus.mem_wdata, 32'h0);
        chk32("reset mem_be", 32'(bus.mem_be), 32'h0);
        chk32("reset i_rdata", bus.i_rdata, 32'h0);
        chk32("reset d_rdata", bus.d_rdata, 32'h0);
        rst_n = 1'b1;
        step();

        // Fetch alone, then store+fetch together with 3-cycle store.
        tbl[0]  = '{4'b1001, 7'b0000100, 32'h0,   32'h0};
        tbl[1]  = '{4'b1001, 7'b1000101, 32'h10,  32'h0};
        tbl[2]  = '{4'b1001, 7'b0010000, 32'h0,   32'h0051_3093};
        tbl[3]  = '{4'b0001, 7'b0000000, 32'h0,   32'h0};
        tbl[4]  = '{4'b1110, 7'b0000110, 32'h0,   32'h0};
        tbl[5]  = '{4'b1110, 7'b1100111, 32'h100, 32'h0};
        tbl[6]  = '{4'b1110, 7'b1100111, 32'h100, 32'h0};
        tbl[7]  = '{4'b1111, 7'b1100111, 32'h100, 32'h0};
        tbl[8]  = '{4'b1111, 7'b1001101, 32'h10,  32'h0};
        tbl[9]  = '{4'b1001, 7'b0010000, 32'h0,   32'h0051_3093};
        tbl[10] = '{4'b0001, 7'b0000000, 32'h0,   32'h0};

        bus.i_addr = 32'h10; bus.d_addr = 32'h100; bus.d_wdata = 32'hDEAD_BEEF;
        bus.d_be = 4'hF; bus.mem_rdata = 32'h0051_3093;
        for (int k = 0; k < 11; k++) begin
            {bus.i_req, bus.d_req, bus.d_we, bus.mem_ready} = tbl[k].ins;
            #1;
            chk1($sformatf("row%0d mem_req", k), bus.mem_req, tbl[k].ex[6]);
            chk1($sformatf("row%0d i_valid", k), bus.i_valid, tbl[k].ex[4]);
            chk1($sformatf("row%0d d_valid", k), bus.d_valid, tbl[k].ex[3]);
            chk1($sformatf("row%0d stall_f", k), bus.stall_f, tbl[k].ex[2]);
            chk1($sformatf("row%0d stall_m", k), bus.stall_m, tbl[k].ex[1]);
            chk1($sformatf("row%0d bus_err", k), bus.bus_err, 1'b0);
            if (tbl[k].ex[6]) chk1($sformatf("row%0d mem_we", k), bus.mem_we, tbl[k].ex[5]);
            if (tbl[k].ex[0]) begin
                chk32($sformatf("row%0d mem_addr", k), bus.mem_addr, tbl[k].e_addr);
                chk32($sformatf("row%0d mem_be", k), 32'(bus.mem_be), 32'hF);
                if (tbl[k].ex[5]) chk32($sformatf("row%0d mem_wdata", k), bus.mem_wdata, 32'hDEAD_BEEF);
            end
            if (tbl[k].ex[4]) chk32($sformatf("row%0d i_rdata", k), bus.i_rdata, tbl[k].e_rdata);
            if (tbl[k].ex[3]) chk32($sformatf("row%0d d_rdata", k), bus.d_rdata, tbl[k].e_rdata);
            step();
        end

        // Load with 5 wait states.
        bus.d_addr = 32'h200; bus.d_we = 1'b0; bus.d_be = 4'b0011; bus.d_wdata = '0;
        bus.mem_ready = 1'b0; bus.mem_rdata = 32'hCAFE_F00D; bus.i_req = 1'b0; bus.d_req = 1'b1;
        #1;
        chk1("ws stall_m at request", bus.stall_m, 1'b1);
        step();
        for (int w = 1; w <= 5; w++) begin
            chk1($sformatf("ws%0d mem_req", w), bus.mem_req, 1'b1);
            chk32($sformatf("ws%0d mem_addr", w), bus.mem_addr, 32'h200);
            chk32($sformatf("ws%0d mem_be", w), 32'(bus.mem_be), 32'hF);
            chk1($sformatf("ws%0d d_valid", w), bus.d_valid, 1'b0);
            chk1($sformatf("ws%0d stall_m", w), bus.stall_m, 1'b1);
            step();
        end
        bus.mem_ready = 1'b1;
        #1;
        chk1("ws ready cycle mem_req", bus.mem_req, 1'b1);
        step();
        chk1("ws d_valid", bus.d_valid, 1'b1);
        chk32("ws d_rdata", bus.d_rdata, 32'hCAFE_F00D);
        chk1("ws stall_m at valid", bus.stall_m, 1'b0);
        chk1("ws bus_err", bus.bus_err, 1'b0);
        bus.d_req = 1'b0; bus.mem_ready = 1'b0;
        step();
        chk1("ws d_valid single pulse", bus.d_valid, 1'b0);
        chk1("ws stall_m after", bus.stall_m, 1'b0);
        chk1("ws idle mem_req", bus.mem_req, 1'b0);

        // Silent memory: data load aborts, pending fetch then completes on the timeout cycle.
        bus.d_addr = 32'h300; bus.d_we = 1'b0; bus.d_be = 4'hF; bus.i_addr = 32'h40;
        bus.mem_ready = 1'b0; bus.d_req = 1'b1; bus.i_req = 1'b1;
        step();
        for (int c = 1; c <= int'(TO); c++) begin
            chk1($sformatf("to busy%0d mem_req", c), bus.mem_req, 1'b1);
            chk32($sformatf("to busy%0d mem_addr", c), bus.mem_addr, 32'h300);
            chk1($sformatf("to busy%0d d_valid", c), bus.d_valid, 1'b0);
            step();
        end
        chk1("to abort d_valid", bus.d_valid, 1'b1);
        chk1("to abort bus_err", bus.bus_err, 1'b1);
        chk32("to abort d_rdata", bus.d_rdata, 32'h0);
        chk1("to fetch granted mem_req", bus.mem_req, 1'b1);
        chk32("to fetch granted mem_addr", bus.mem_addr, 32'h40);
        chk1("to fetch granted mem_we", bus.mem_we, 1'b0);
        chk1("to stall_f", bus.stall_f, 1'b1);
        bus.d_req = 1'b0;
        step();
        for (int c = 2; c < int'(TO); c++) begin
            chk1($sformatf("edge busy%0d mem_req", c), bus.mem_req, 1'b1);
            chk1($sformatf("edge busy%0d i_valid", c), bus.i_valid, 1'b0);
            step();
        end
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'h1234_5678;
        #1;
        chk1("edge last busy mem_req", bus.mem_req, 1'b1);
        step();
        chk1("edge i_valid", bus.i_valid, 1'b1);
        chk1("edge bus_err", bus.bus_err, 1'b0);
        chk32("edge i_rdata", bus.i_rdata, 32'h1234_5678);
        chk1("edge then idle", bus.mem_req, 1'b0);
        bus.i_req = 1'b0; bus.mem_ready = 1'b0;
        step();

        // Reset in the middle of a store.
        bus.d_addr = 32'h500; bus.d_we = 1'b1; bus.d_wdata = 32'h1111_2222; bus.d_be = 4'hC;
        bus.d_req = 1'b1;
        step();
        chk1("rst pre mem_req", bus.mem_req, 1'b1);
        step();
        #2 rst_n = 1'b0;
        #1;
        chk1("rst async mem_req", bus.mem_req, 1'b0);
        chk1("rst async mem_we", bus.mem_we, 1'b0);
        chk1("rst async d_valid", bus.d_valid, 1'b0);
        chk1("rst async bus_err", bus.bus_err, 1'b0);
        chk32("rst async mem_addr", bus.mem_addr, 32'h0);
        bus.d_req = 1'b0; bus.d_we = 1'b0;
        step();
        step();
        chk1("rst held no d_valid", bus.d_valid, 1'b0);
        rst_n = 1'b1;
        step();
        bus.i_addr = 32'h20; bus.mem_ready = 1'b1; bus.mem_rdata = 32'hA5A5_0001; bus.i_req = 1'b1;
        #1;
        chk1("post-rst idle mem_req", bus.mem_req, 1'b0);
        step();
        chk1("post-rst mem_req", bus.mem_req, 1'b1);
        chk32("post-rst mem_addr", bus.mem_addr, 32'h20);
        step();
        chk1("post-rst i_valid", bus.i_valid, 1'b1);
        chk32("post-rst i_rdata", bus.i_rdata, 32'hA5A5_0001);
        bus.i_req = 1'b0; bus.mem_ready = 1'b0;
        step();

        // Random concurrent traffic.
        for (int i = 0; i < 16; i++) begin
            ref_mem[i]  = $urandom;
            phys_mem[i] = ref_mem[i];
        end
        fork
            run_fetch(40);
            run_data(60);
            run_mem();
        join
        repeat (2) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
